// File: rtl/outbus_pkg.sv
// Shared bus definitions for the output bus arbiter and the peripherals on that bus.
// Holds the default bus widths and the requester-index width helper.
package outbus_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 8;
  localparam int DATA_WIDTH_DEFAULT = 8;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/outbus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of valid at or above ptr, wrapping.
// Returns the one-hot grant, its index, and whether any grant was made.
module rr_picker
  import outbus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index,
  output logic               any_grant
);

  localparam int SUM_W = IDX_W + 1;

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SUM_W-1:0]     offset;
  logic [SUM_W-1:0]     sum;

  // Rotate so that bit 0 of rot corresponds to requester ptr.
  always_comb begin
    dbl = {valid, valid} >> ptr;
    rot = dbl[NUM_REQ-1:0];
  end

  // Highest k is visited first so the lowest rotated offset wins.
  always_comb begin
    offset    = '0;
    any_grant = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        offset    = SUM_W'(k);
        any_grant = 1'b1;
      end
    end
  end

  always_comb begin
    sum = {1'b0, ptr} + offset;
    if (sum >= SUM_W'(NUM_REQ)) begin
      sum = sum - SUM_W'(NUM_REQ);
    end
    index = sum[IDX_W-1:0];
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = any_grant && (index == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/outbus_arbiter.sv
// Round-robin arbiter driving a single registered write bus from NUM_REQ requesters.
// Grant is combinational; the bus beat appears one cycle after the grant.
module outbus_arbiter
  import outbus_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          bus_stall,
  output logic [ADDR_WIDTH-1:0]         OUTBUS_ADDR,
  output logic [DATA_WIDTH-1:0]         OUTBUS_DATA,
  output logic                          OUTBUS_WE,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  logic [NUM_REQ-1:0]    valid_eff;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      win_index;
  logic                  any_grant;

  logic [IDX_W-1:0]      ptr_reg, ptr_next;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [IDX_W-1:0]      gid_reg;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Reset and stall both mask requests before the search, so no grant can leak out.
  assign valid_eff = (reset || bus_stall) ? '0 : req_valid;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid     (valid_eff),
    .ptr       (ptr_reg),
    .grant     (grant),
    .index     (win_index),
    .any_grant (any_grant)
  );

  assign req_ready = grant;

  always_comb begin
    ptr_next = ptr_reg;
    if (any_grant) begin
      ptr_next = (win_index == IDX_W'(NUM_REQ - 1)) ? '0 : win_index + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg  <= '0;
      we_reg   <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
      gid_reg  <= '0;
    end else begin
      ptr_reg <= ptr_next;
      we_reg  <= any_grant;
      if (any_grant) begin
        addr_reg <= addr_arr[win_index];
        data_reg <= data_arr[win_index];
        gid_reg  <= win_index;
      end
    end
  end

  assign OUTBUS_WE   = we_reg;
  assign OUTBUS_ADDR = addr_reg;
  assign OUTBUS_DATA = data_reg;
  assign grant_id    = gid_reg;

endmodule

// File: tb/tb_outbus_arbiter.sv
// Directed bench for outbus_arbiter: inputs change on the falling edge, outputs are
// checked just after it, well away from the rising edge.
`timescale 1ns/1ps
module tb_outbus_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          bus_stall;
  logic [AW-1:0] OUTBUS_ADDR;
  logic [DW-1:0] OUTBUS_DATA;
  logic          OUTBUS_WE;
  logic [1:0]    grant_id;

  int checks;
  int errors;

  outbus_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .bus_stall   (bus_stall),
    .OUTBUS_ADDR (OUTBUS_ADDR),
    .OUTBUS_DATA (OUTBUS_DATA),
    .OUTBUS_WE   (OUTBUS_WE),
    .grant_id    (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    req_valid = '0;
    bus_stall = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step();
    reset = 1'b1;
    req_valid = '0;
    bus_stall = 1'b0;
    step();
    step();
    #1;
    checks++;
    if (req_ready !== 4'b0000 || OUTBUS_WE !== 1'b0 || OUTBUS_ADDR !== 8'h00 ||
        OUTBUS_DATA !== 8'h00 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b we=%b addr=%h data=%h gid=%0d, required all zero",
               req_ready, OUTBUS_WE, OUTBUS_ADDR, OUTBUS_DATA, grant_id);
    end else
      $display("reset_state ok");
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      #1;
      checks++;
      if (req_ready !== 4'b0000 || OUTBUS_WE !== 1'b0 || OUTBUS_ADDR !== 8'h00 ||
          OUTBUS_DATA !== 8'h00 || grant_id !== 2'd0) begin
        errors++;
        $display("FAIL idle_cycle%0d: ready=%b we=%b addr=%h data=%h gid=%0d, required all zero",
                 c, req_ready, OUTBUS_WE, OUTBUS_ADDR, OUTBUS_DATA, grant_id);
      end
    end
    $display("idle 20 cycles checked");
  endtask

  task automatic test_single();
    // ptr is 0 here; requester 2 is the only one valid.
    step();
    req_addr[2*AW +: AW] = 8'h05;
    req_data[2*DW +: DW] = 8'hA5;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b, required 0100", req_ready);
    end else
      $display("single grant: ready=%b", req_ready);
    step();
    req_valid = '0;
    #1;
    checks++;
    if (OUTBUS_WE !== 1'b1 || OUTBUS_ADDR !== 8'h05 || OUTBUS_DATA !== 8'hA5 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_beat: we=%b addr=%h data=%h gid=%0d, required 1 05 a5 2",
               OUTBUS_WE, OUTBUS_ADDR, OUTBUS_DATA, grant_id);
    end else
      $display("single beat: addr=%h data=%h gid=%0d", OUTBUS_ADDR, OUTBUS_DATA, grant_id);
    step();
    #1;
    checks++;
    if (OUTBUS_WE !== 1'b0 || OUTBUS_ADDR !== 8'h05 || OUTBUS_DATA !== 8'hA5 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_hold: we=%b addr=%h data=%h gid=%0d, required 0 05 a5 2",
               OUTBUS_WE, OUTBUS_ADDR, OUTBUS_DATA, grant_id);
    end else
      $display("single hold: we=0, values held");
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_id;
    logic [N-1:0] exp_ready;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = 8'h10 + 8'(i);
      req_data[i*DW +: DW] = 8'hC0 + 8'(i);
    end
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) step();
      if (k < 6) req_valid = 4'b1111;
      else req_valid = '0;
      #1;
      if (k > 0) begin
        exp_id = 2'((k - 1) % N);
        checks++;
        if (OUTBUS_WE !== 1'b1 || grant_id !== exp_id ||
            OUTBUS_ADDR !== (8'h10 + 8'(exp_id)) || OUTBUS_DATA !== (8'hC0 + 8'(exp_id))) begin
          errors++;
          $display("FAIL b2b_beat%0d: we=%b gid=%0d addr=%h data=%h, required 1 %0d %h %h",
                   k - 1, OUTBUS_WE, grant_id, OUTBUS_ADDR, OUTBUS_DATA, exp_id,
                   8'h10 + 8'(exp_id), 8'hC0 + 8'(exp_id));
        end else
          $display("b2b beat %0d: gid=%0d addr=%h", k - 1, grant_id, OUTBUS_ADDR);
      end
      if (k < 6) begin
        exp_ready = 4'b0001 << (k % N);
        checks++;
        if (req_ready !== exp_ready) begin
          errors++;
          $display("FAIL b2b_ready%0d: got %b, required %b", k, req_ready, exp_ready);
        end
      end
    end
  endtask

  task automatic test_ptr_skip();
    // After six grants from ptr 0 the pointer sits at 2.
    req_addr[1*AW +: AW] = 8'h31;
    req_addr[3*AW +: AW] = 8'h33;
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL ptr_first: got %b, required 1000", req_ready);
    end else
      $display("ptr skip: requester 3 first");
    step();
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010 || OUTBUS_WE !== 1'b1 || grant_id !== 2'd3 || OUTBUS_ADDR !== 8'h33) begin
      errors++;
      $display("FAIL ptr_second: ready=%b we=%b gid=%0d addr=%h, required 0010 1 3 33",
               req_ready, OUTBUS_WE, grant_id, OUTBUS_ADDR);
    end else
      $display("ptr skip: requester 1 second");
    step();
    req_valid = '0;
    #1;
    checks++;
    if (OUTBUS_WE !== 1'b1 || grant_id !== 2'd1 || OUTBUS_ADDR !== 8'h31) begin
      errors++;
      $display("FAIL ptr_beat1: we=%b gid=%0d addr=%h, required 1 1 31", OUTBUS_WE, grant_id, OUTBUS_ADDR);
    end else
      $display("ptr skip beat: gid=%0d", grant_id);
  endtask

  task automatic test_stall();
    // ptr is 2 here.
    step();
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL stall_pre: got %b, required 0100", req_ready);
    end else
      $display("stall pre-grant: ready=%b", req_ready);
    for (int c = 0; c < 3; c++) begin
      step();
      bus_stall = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0000 || OUTBUS_WE !== (c == 0 ? 1'b1 : 1'b0) ||
          (c == 0 && grant_id !== 2'd2)) begin
        errors++;
        $display("FAIL stall_cycle%0d: ready=%b we=%b gid=%0d, required 0000 %b",
                 c, req_ready, OUTBUS_WE, grant_id, (c == 0 ? 1'b1 : 1'b0));
      end else
        $display("stall cycle %0d: ready=%b we=%b", c, req_ready, OUTBUS_WE);
    end
    step();
    bus_stall = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b1000 || OUTBUS_WE !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: ready=%b we=%b, required 1000 0", req_ready, OUTBUS_WE);
    end else
      $display("stall release: resumes at requester 3");
    step();
    req_valid = '0;
    #1;
    checks++;
    if (OUTBUS_WE !== 1'b1 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL stall_resume_beat: we=%b gid=%0d, required 1 3", OUTBUS_WE, grant_id);
    end else
      $display("stall resume beat: gid=%0d", grant_id);
  endtask

  task automatic test_drop();
    // A request withdrawn while stalled never produces a beat.
    step();
    bus_stall = 1'b1;
    req_valid = 4'b0001;
    step();
    bus_stall = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if (OUTBUS_WE !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL drop_nobeat: we=%b ready=%b, required 0 0000", OUTBUS_WE, req_ready);
    end
    step();
    #1;
    checks++;
    if (OUTBUS_WE !== 1'b0) begin
      errors++;
      $display("FAIL drop_nobeat2: we=%b, required 0", OUTBUS_WE);
    end else
      $display("dropped request: no beat");
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rmid_grant: got %b, required 0100", req_ready);
    end
    step();
    // Beat from requester 2 is on the bus; ptr is now 3. Reset with a would-be grant pending.
    req_valid = 4'b1111;
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || OUTBUS_WE !== 1'b1 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL rmid_during: ready=%b we=%b gid=%0d, required 0000 1 2", req_ready, OUTBUS_WE, grant_id);
    end else
      $display("reset mid-stream: grants blocked");
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (OUTBUS_WE !== 1'b0 || grant_id !== 2'd0 || OUTBUS_ADDR !== 8'h00 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_after: we=%b gid=%0d addr=%h ready=%b, required 0 0 00 0001",
               OUTBUS_WE, grant_id, OUTBUS_ADDR, req_ready);
    end else
      $display("after reset: we=0, grant from requester 0");
    step();
    req_valid = '0;
    #1;
    checks++;
    if (OUTBUS_WE !== 1'b1 || grant_id !== 2'd0 || OUTBUS_ADDR !== 8'h10) begin
      errors++;
      $display("FAIL rmid_beat: we=%b gid=%0d addr=%h, required 1 0 10", OUTBUS_WE, grant_id, OUTBUS_ADDR);
    end else
      $display("post-reset beat: gid=%0d", grant_id);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    bus_stall = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_ptr_skip();
    test_stall();
    test_drop();
    test_reset_mid();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
